// File: rtl/post_tx_arbiter.sv
// Round-robin arbiter sharing the POST INPUT byte path between NREQ sources,
// locking the port to one source for up to BURST bytes of a message.
module post_tx_arbiter #(
    parameter int NREQ    = 2,
    parameter int BURST   = 16,
    parameter int HOLD_TO = 64
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        txin,
    output logic              tx_pending,
    input  logic              tx_taken,
    output logic [NREQ-1:0]   grant,
    output logic              busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, PEND, WAIT} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   rr_ptr, rr_ptr_nx, owner, owner_nx, win;
    logic [7:0]      burst_cnt, burst_cnt_nx, hold_cnt, hold_cnt_nx, txin_nx;
    logic            last_f, last_f_nx, tx_pending_nx, found;
    logic [NREQ-1:0] grant_nx, ready_c;

    function automatic logic [7:0] src_byte(input logic [IW-1:0] i);
        return req_data[{i, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] burst_inc(input logic [7:0] cnt);
        return (cnt >= 8'(BURST)) ? cnt : cnt + 8'd1;
    endfunction

    // First valid source at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        state_nx      = state;
        rr_ptr_nx     = rr_ptr;
        owner_nx      = owner;
        burst_cnt_nx  = burst_cnt;
        hold_cnt_nx   = hold_cnt;
        txin_nx       = txin;
        tx_pending_nx = tx_pending;
        grant_nx      = grant;
        last_f_nx     = last_f;
        ready_c       = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    ready_c[win]  = 1'b1;
                    txin_nx       = src_byte(win);
                    tx_pending_nx = 1'b1;
                    grant_nx      = '0;
                    grant_nx[win] = 1'b1;
                    owner_nx      = win;
                    burst_cnt_nx  = 8'd1;
                    last_f_nx     = req_last[win];
                    state_nx      = PEND;
                end
            end
            PEND: begin
                if (tx_taken) begin
                    if (!last_f && burst_cnt < 8'(BURST)) begin
                        if (req_valid[owner]) begin
                            ready_c[owner] = 1'b1;
                            txin_nx        = src_byte(owner);
                            burst_cnt_nx   = burst_inc(burst_cnt);
                            last_f_nx      = req_last[owner];
                        end else begin
                            tx_pending_nx = 1'b0;
                            hold_cnt_nx   = 8'd0;
                            state_nx      = WAIT;
                        end
                    end else begin
                        tx_pending_nx = 1'b0;
                        grant_nx      = '0;
                        rr_ptr_nx     = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
                        state_nx      = IDLE;
                    end
                end
            end
            WAIT: begin
                if (req_valid[owner]) begin
                    ready_c[owner] = 1'b1;
                    txin_nx        = src_byte(owner);
                    tx_pending_nx  = 1'b1;
                    burst_cnt_nx   = burst_inc(burst_cnt);
                    last_f_nx      = req_last[owner];
                    state_nx       = PEND;
                end else if (hold_cnt == 8'(HOLD_TO - 1)) begin
                    grant_nx  = '0;
                    rr_ptr_nx = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
                    state_nx  = IDLE;
                end else begin
                    hold_cnt_nx = hold_cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Reset also discards any byte held in txin; the source is not asked again.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            burst_cnt  <= 8'd0;
            hold_cnt   <= 8'd0;
            txin       <= 8'd0;
            tx_pending <= 1'b0;
            grant      <= '0;
            last_f     <= 1'b0;
        end else begin
            state      <= state_nx;
            rr_ptr     <= rr_ptr_nx;
            owner      <= owner_nx;
            burst_cnt  <= burst_cnt_nx;
            hold_cnt   <= hold_cnt_nx;
            txin       <= txin_nx;
            tx_pending <= tx_pending_nx;
            grant      <= grant_nx;
            last_f     <= last_f_nx;
        end
    end

    assign req_ready = rst_n ? ready_c : '0;
    assign busy      = (state != IDLE);

endmodule
